muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit for the single-cycle core, sitting directly upstream of the register file write port.
- Consumes the two register-file read operands and the destination index, and produces a result plus a one-cycle done strobe.
- The core uses the done strobe as the register-file write enable, with A3 = rd_out and WD3 = result.
- The core stalls the PC while busy is high.

Parameters:
- WIDTH, 32, operand/result width; iteration counter is clog2(WIDTH)+1 bits.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request to begin an operation; sampled only in IDLE.
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  WIDTH  rs1 value (multiplicand / dividend).
- op_b  input  WIDTH  rs2 value (multiplier / divisor).
- rd_in  input  5  destination register index.
- busy  output  1  high while iterating (RUN state).
- done  output  1  one-cycle pulse; result and rd_out are valid this cycle.
- result  output  WIDTH  operation result.
- rd_out  output  5  destination index latched at start.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high, and has priority over all other inputs.
- Reset values:
  - state = IDLE
  - busy = 0, done = 0
  - result = 0, rd_out = 0
  - internal accumulators and counter = 0
- State machine: IDLE, RUN, DONE.
- IDLE:
  - start=1: latch funct3, rd_in, and operand magnitudes/signs.
  - Special-case division (see below) goes to DONE; everything else goes to RUN with counter = 0.
  - start=0: stay in IDLE.
- RUN:
  - One radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide.
  - busy = 1. After WIDTH steps go to DONE.
  - start is ignored.
- DONE:
  - done = 1 for exactly one cycle; result and rd_out are driven from the final values.
  - Next state is IDLE unconditionally.
  - start is ignored, so the still-presented instruction does not re-trigger.
- Latency:
  - Normal op: start sampled at edge k gives done high in the cycle after edge k+WIDTH, i.e. 33 cycles after the start cycle for WIDTH=32.
  - busy is high for exactly WIDTH cycles.
- Special-case latency: done is high in the cycle immediately after the start cycle; busy stays 0.
- Signed handling:
  - Operate on magnitudes, then negate the final value where required.
  - MUL, MULH: both operands signed. MULHSU: op_a signed, op_b unsigned. MULHU: both unsigned.
  - MUL returns the low WIDTH bits of the 2*WIDTH product; MULH* return the high WIDTH bits.
  - DIV: quotient sign = sign(a) XOR sign(b). REM: remainder sign = sign(a).
  - Quotient truncates toward zero.
- Division by zero (op_b = 0), special case:
  - DIV, DIVU: result = all ones.
  - REM, REMU: result = op_a.
- Signed overflow (DIV/REM with op_a = 0x80000000 and op_b = 0xFFFFFFFF), special case:
  - DIV: result = 0x80000000.
  - REM: result = 0.
- Output hold: result and rd_out hold their values after done until the next accepted start.
- Reset mid-operation: the operation aborts, no done is emitted, and busy = 0 in the cycle after the reset edge.
- Operand sampling: op_a and op_b are sampled only at acceptance, so input changes during RUN have no effect.

Test Plan:
- MUL, op_a=7, op_b=0xFFFFFFFD (-3), rd_in=5, start 1 cycle -> busy high 32 cycles; done one cycle 33 cycles after start; result=0xFFFFFFEB, rd_out=5.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Special cases, each with done 1 cycle after start and busy never high:
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- start held high through RUN and DONE with changing op_a/op_b -> exactly one done; result from the operands at acceptance. A new op is accepted only in IDLE.
- rst asserted at cycle 10 of a DIV -> no done; busy=0, result=0 next cycle. A following MUL 3x4 -> result 12 with normal latency.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// with sign correction applied to the final value. Division by zero and
// signed overflow bypass the iteration and complete in a single cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [4:0]       rd_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       rd_out
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state;
    logic [CW-1:0]      counter;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   addend;
    logic [2:0]         op_q;
    logic               neg_q;

    // Acceptance decode: operand signedness, magnitudes and special cases
    logic             in_is_div;
    logic             in_sgn_a;
    logic             in_sgn_b;
    logic             in_neg_a;
    logic             in_neg_b;
    logic [WIDTH-1:0] in_mag_a;
    logic [WIDTH-1:0] in_mag_b;
    logic             in_neg;
    logic             in_div_zero;
    logic             in_div_ovf;
    logic [WIDTH-1:0] in_special;

    // Decode the presented instruction into magnitudes, the final sign and any special case
    always_comb begin
        in_is_div = funct3[2];
        if (in_is_div) begin
            in_sgn_a = ~funct3[0];
            in_sgn_b = ~funct3[0];
        end else begin
            in_sgn_a = (funct3 != 3'b011);
            in_sgn_b = ~funct3[1];
        end
        in_neg_a = in_sgn_a & op_a[WIDTH-1];
        in_neg_b = in_sgn_b & op_b[WIDTH-1];
        in_mag_a = in_neg_a ? -op_a : op_a;
        in_mag_b = in_neg_b ? -op_b : op_b;
        if (in_is_div && funct3[1]) begin
            in_neg = in_neg_a;
        end else begin
            in_neg = in_neg_a ^ in_neg_b;
        end
        in_div_zero = in_is_div && (op_b == '0);
        in_div_ovf  = in_is_div && !funct3[0] && (op_a == MIN_NEG) && (op_b == ALL_ONES);
        if (in_div_zero) begin
            in_special = funct3[1] ? op_a : ALL_ONES;
        end else begin
            in_special = funct3[1] ? '0 : MIN_NEG;
        end
    end

    // Datapath for one iteration and the sign-corrected value it would finish with
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] signed_acc;
    logic [WIDTH-1:0]   rem_mag;
    logic [WIDTH-1:0]   step_result;

    // One radix-2 step: multiply keeps the product in acc, divide keeps {remainder, quotient}
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, addend} : {(WIDTH+1){1'b0}});
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, addend};
        if (op_q[2]) begin
            if (!div_diff[WIDTH]) begin
                acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    // Final value: negating the full double-width word also gives the negated quotient in its low half
    always_comb begin
        signed_acc = neg_q ? -acc_next : acc_next;
        rem_mag    = acc_next[2*WIDTH-1:WIDTH];
        case (op_q)
            3'b000:                 step_result = signed_acc[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: step_result = signed_acc[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         step_result = signed_acc[WIDTH-1:0];
            default:                step_result = neg_q ? -rem_mag : rem_mag;
        endcase
    end

    // Control FSM with registered busy/done/result/rd_out
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            counter <= '0;
            acc     <= '0;
            addend  <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            rd_out  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        rd_out  <= rd_in;
                        op_q    <= funct3;
                        neg_q   <= in_neg;
                        counter <= '0;
                        if (in_div_zero || in_div_ovf) begin
                            result <= in_special;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            if (in_is_div) begin
                                acc    <= {{WIDTH{1'b0}}, in_mag_a};
                                addend <= in_mag_b;
                            end else begin
                                acc    <= {{WIDTH{1'b0}}, in_mag_b};
                                addend <= in_mag_a;
                            end
                            busy  <= 1'b1;
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    acc     <= acc_next;
                    counter <= counter + CW'(1);
                    if (counter == CW'(WIDTH - 1)) begin
                        result <= step_result;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

    localparam int W = 32;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic          clk;
    logic          rst;
    logic          start;
    logic [2:0]    funct3;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [4:0]    rd_in;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic [4:0]    rd_out;

    int checks;
    int errors;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference RV32M semantics using 64-bit products and native signed division
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        int ia, ib;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        ia = a;
        ib = b;
        p  = '0;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN_NEG && b == 32'hFFFF_FFFF) return MIN_NEG;
                return 32'(ia / ib);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return f3[2] && ((b == 0) || (!f3[0] && a == MIN_NEG && b == 32'hFFFF_FFFF));
    endfunction

    // Issue one op with a single-cycle start, scramble operands while it runs, observe completion
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                          output int lat, output int busy_cnt, output bit seen);
        @(negedge clk);
        start  = 1'b1;
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        rd_in  = rd;
        @(negedge clk);
        start  = 1'b0;
        funct3 = 3'($urandom);
        op_a   = $urandom;
        op_b   = $urandom;
        rd_in  = 5'($urandom);
        seen     = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        res      = '0;
        rdo      = '0;
        for (int i = 1; i <= 60 && !seen; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1'b1;
                lat  = i;
                res  = result;
                rdo  = rd_out;
            end else begin
                @(negedge clk);
                op_a = $urandom;
                op_b = $urandom;
            end
        end
        if (seen) @(negedge clk);
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        start  = 1'b0;
        funct3 = '0;
        op_a   = '0;
        op_b   = '0;
        rd_in  = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_ctrl busy/done got %b expected 00", {busy, done});
        end
        checks++;
        if (result !== 32'd0 || rd_out !== 5'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs result %h rd_out %0d expected 0/0", result, rd_out);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t vecs[12];
        logic [31:0] res;
        logic [4:0]  rdo;
        int lat, bc;
        bit seen;
        vecs[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14,        33};
        vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2,         33};
        vecs[8]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd7, 32'd5,         32'd0,         32'd5,         1};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 5), res, rdo, lat, bc, seen);
            checks++;
            if (!seen) begin
                errors++;
                $display("[TB] FAIL dir%0d_timeout no done within 60 cycles", i);
            end
            checks++;
            if (res !== vecs[i].exp) begin
                errors++;
                $display("[TB] FAIL dir%0d_result got %h expected %h", i, res, vecs[i].exp);
            end
            checks++;
            if (rdo !== 5'(i + 5)) begin
                errors++;
                $display("[TB] FAIL dir%0d_rd got %0d expected %0d", i, rdo, i + 5);
            end
            checks++;
            if (lat != vecs[i].lat) begin
                errors++;
                $display("[TB] FAIL dir%0d_latency got %0d expected %0d", i, lat, vecs[i].lat);
            end
            checks++;
            if (bc != ((vecs[i].lat == 1) ? 0 : W)) begin
                errors++;
                $display("[TB] FAIL dir%0d_busy_cycles got %0d expected %0d", i, bc, (vecs[i].lat == 1) ? 0 : W);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b, exp, res;
        logic [4:0]  rd, rdo;
        int lat, bc, exp_lat;
        bit seen;
        for (int i = 0; i < 60; i++) begin
            f3 = 3'($urandom);
            a  = $urandom;
            b  = $urandom;
            rd = 5'($urandom);
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = MIN_NEG; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 20));
                3: a = 32'($urandom_range(0, 1000));
                default: ;
            endcase
            exp     = model(f3, a, b);
            exp_lat = is_special(f3, a, b) ? 1 : W + 1;
            run_op(f3, a, b, rd, res, rdo, lat, bc, seen);
            checks++;
            if (!seen || res !== exp) begin
                errors++;
                $display("[TB] FAIL rand%0d_result f3 %0d a %h b %h got %h expected %h done_seen %0d", i, f3, a, b, res, exp, seen);
            end
            checks++;
            if (rdo !== rd) begin
                errors++;
                $display("[TB] FAIL rand%0d_rd got %0d expected %0d", i, rdo, rd);
            end
            checks++;
            if (lat != exp_lat || bc != exp_lat - 1) begin
                errors++;
                $display("[TB] FAIL rand%0d_timing latency %0d busy %0d expected %0d/%0d", i, lat, bc, exp_lat, exp_lat - 1);
            end
        end
    endtask

    task automatic test_output_hold();
        logic [31:0] res;
        logic [4:0]  rdo;
        int lat, bc;
        bit seen;
        run_op(3'd0, 32'd1234, 32'd5678, 5'd17, res, rdo, lat, bc, seen);
        for (int i = 0; i < 10; i++) begin
            funct3 = 3'($urandom);
            op_a   = $urandom;
            op_b   = $urandom;
            rd_in  = 5'($urandom);
            @(negedge clk);
            checks++;
            if (result !== 32'd7006652 || rd_out !== 5'd17 || done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold%0d result %h rd_out %0d done %b expected %h/17/0", i, result, rd_out, done, 32'd7006652);
            end
        end
    endtask

    task automatic test_start_held();
        int n_done, bc, after_busy, after_done;
        logic [31:0] res;
        logic [4:0]  rdo;
        bit seen;
        @(negedge clk);
        start  = 1'b1;
        funct3 = 3'd5;
        op_a   = 32'd100;
        op_b   = 32'd7;
        rd_in  = 5'd9;
        n_done = 0;
        bc     = 0;
        seen   = 1'b0;
        res    = '0;
        rdo    = '0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) begin
                seen = 1'b1;
                n_done++;
                res = result;
                rdo = rd_out;
            end
            op_a = $urandom;
            op_b = $urandom;
        end
        @(negedge clk);
        start = 1'b0;
        after_busy = 0;
        after_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) after_busy++;
            if (done) after_done++;
            @(negedge clk);
        end
        checks++;
        if (n_done + after_done != 1) begin
            errors++;
            $display("[TB] FAIL held_done_count got %0d expected 1", n_done + after_done);
        end
        checks++;
        if (res !== 32'd14 || rdo !== 5'd9) begin
            errors++;
            $display("[TB] FAIL held_result got %h rd %0d expected %h rd 9", res, rdo, 32'd14);
        end
        checks++;
        if (bc != W || after_busy != 0) begin
            errors++;
            $display("[TB] FAIL held_busy got %0d then %0d expected %0d then 0", bc, after_busy, W);
        end
    endtask

    task automatic test_reset_mid();
        int n_done;
        logic [31:0] res;
        logic [4:0]  rdo;
        int lat, bc;
        bit seen;
        @(negedge clk);
        start  = 1'b1;
        funct3 = 3'd4;
        op_a   = 32'd1000;
        op_b   = 32'd3;
        rd_in  = 5'd12;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || rd_out !== 5'd0) begin
            errors++;
            $display("[TB] FAIL midreset_state busy %b done %b result %h rd %0d expected 0", busy, done, result, rd_out);
        end
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        checks++;
        if (n_done != 0) begin
            errors++;
            $display("[TB] FAIL midreset_activity got %0d active cycles expected 0", n_done);
        end
        run_op(3'd0, 32'd3, 32'd4, 5'd3, res, rdo, lat, bc, seen);
        checks++;
        if (!seen || res !== 32'd12 || rdo !== 5'd3) begin
            errors++;
            $display("[TB] FAIL post_reset_mul got %h rd %0d expected %h rd 3", res, rdo, 32'd12);
        end
        checks++;
        if (lat != W + 1) begin
            errors++;
            $display("[TB] FAIL post_reset_latency got %0d expected %0d", lat, W + 1);
        end
    endtask

    // Test sequence
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_output_hold();
        test_start_held();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
